// File: rtl/linear_layer_start_fifo_ctrl.sv
// Shift-register FIFO control for Linear_Layer dataflow start/stream channels.
// HLS full_n/empty_n handshakes, first-word-fall-through head, occupancy and high-water stats.
module linear_layer_start_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic [ADDR_WIDTH:0]   high_water,
  input  logic                  hw_clear
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic [CW-1:0]         hw_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  push_c;
  logic                  pop_c;

  // Flags are registered, so accepts are qualified by the current flag state.
  assign push_c = if_write & if_write_ce & if_full_n;
  assign pop_c  = if_read & if_read_ce & if_empty_n;

  // Next occupancy/address; addr stays pinned at 0 across the 0<->1 transitions.
  always_comb begin
    cnt_next  = cnt;
    addr_next = addr;
    hw_next   = high_water;
    if (push_c && !pop_c) begin
      cnt_next = cnt + CW'(1);
      if (cnt != '0) begin
        addr_next = addr + ADDR_WIDTH'(1);
      end
    end else if (pop_c && !push_c) begin
      cnt_next = cnt - CW'(1);
      if (cnt != CW'(1)) begin
        addr_next = addr - ADDR_WIDTH'(1);
      end
    end
    if (hw_clear) begin
      hw_next = cnt_next;
    end else if (cnt_next > high_water) begin
      hw_next = cnt_next;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt        <= '0;
      addr       <= '0;
      high_water <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      addr       <= addr_next;
      high_water <= hw_next;
      if_empty_n <= (cnt_next != '0);
      if_full_n  <= (cnt_next != CW'(DEPTH));
    end
  end

  // Storage is intentionally not reset; new data always enters entry 0.
  always_ff @(posedge ap_clk) begin
    if (push_c && ap_rst_n) begin
      mem[0] <= if_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign if_dout   = mem[addr];
  assign occupancy = cnt;

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Bench for linear_layer_start_fifo_ctrl: a DEPTH=2 and a DEPTH=4 instance with
// a data scoreboard per instance and directed status checks.
module tb_linear_layer_start_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: DEPTH=2, ADDR_WIDTH=1
  logic       a_wce, a_w, a_din, a_full_n, a_rce, a_r, a_dout, a_empty_n, a_hwclr;
  logic [1:0] a_occ, a_hw;
  // Instance B: DEPTH=4, ADDR_WIDTH=2
  logic       b_wce, b_w, b_din, b_full_n, b_rce, b_r, b_dout, b_empty_n, b_hwclr;
  logic [2:0] b_occ, b_hw;

  logic a_exp[$];
  logic b_exp[$];

  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .if_write_ce(a_wce), .if_write(a_w), .if_din(a_din), .if_full_n(a_full_n),
    .if_read_ce(a_rce), .if_read(a_r), .if_dout(a_dout), .if_empty_n(a_empty_n),
    .occupancy(a_occ), .high_water(a_hw), .hw_clear(a_hwclr)
  );

  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(2), .DEPTH(4)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .if_write_ce(b_wce), .if_write(b_w), .if_din(b_din), .if_full_n(b_full_n),
    .if_read_ce(b_rce), .if_read(b_r), .if_dout(b_dout), .if_empty_n(b_empty_n),
    .occupancy(b_occ), .high_water(b_hw), .hw_clear(b_hwclr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare the head against the scoreboard whenever a pop is accepted.
  always @(negedge clk) begin
    if (rst_n && a_r && a_rce && a_empty_n) begin
      if (a_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_dout: pop with no expected entry (t=%0t)", $time);
      end else begin
        chk("a_dout", int'(a_dout), int'(a_exp.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_r && b_rce && b_empty_n) begin
      if (b_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_dout: pop with no expected entry (t=%0t)", $time);
      end else begin
        chk("b_dout", int'(b_dout), int'(b_exp.pop_front()));
      end
    end
  end

  initial begin
    logic stream [8];
    stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    {a_wce, a_w, a_din, a_rce, a_r, a_hwclr} = '0;
    {b_wce, b_w, b_din, b_rce, b_r, b_hwclr} = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state, both instances
    chk("a_rst_empty_n", a_empty_n, 0);
    chk("a_rst_full_n", a_full_n, 1);
    chk("a_rst_occ", a_occ, 0);
    chk("a_rst_hw", a_hw, 0);
    chk("b_rst_empty_n", b_empty_n, 0);
    chk("b_rst_full_n", b_full_n, 1);
    chk("b_rst_occ", b_occ, 0);
    chk("b_rst_hw", b_hw, 0);

    // CE low: request ignored
    a_w = 1'b1; a_din = 1'b1; a_wce = 1'b0;
    tick();
    chk("a_ce_low_occ", a_occ, 0);
    chk("a_ce_low_empty_n", a_empty_n, 0);

    // A: push 1 then 0
    a_wce = 1'b1; a_w = 1'b1; a_din = 1'b1; a_exp.push_back(1'b1);
    tick();
    chk("a_push1_empty_n", a_empty_n, 1);
    chk("a_push1_occ", a_occ, 1);
    chk("a_push1_full_n", a_full_n, 1);
    chk("a_push1_dout", a_dout, 1);
    a_din = 1'b0; a_exp.push_back(1'b0);
    tick();
    a_w = 1'b0;
    chk("a_full_full_n", a_full_n, 0);
    chk("a_full_occ", a_occ, 2);
    chk("a_full_dout", a_dout, 1);
    chk("a_full_hw", a_hw, 2);

    // A: pop twice from full
    a_rce = 1'b1; a_r = 1'b1;
    tick();
    chk("a_pop1_full_n", a_full_n, 1);
    chk("a_pop1_occ", a_occ, 1);
    tick();
    a_r = 1'b0;
    chk("a_pop2_empty_n", a_empty_n, 0);
    chk("a_pop2_occ", a_occ, 0);

    // A: refill, then push-while-full with simultaneous pop (push dropped)
    a_w = 1'b1; a_din = 1'b1; a_exp.push_back(1'b1);
    tick();
    a_din = 1'b0; a_exp.push_back(1'b0);
    tick();
    a_din = 1'b1; a_r = 1'b1;
    tick();
    a_w = 1'b0;
    chk("a_fullpp_occ", a_occ, 1);
    chk("a_fullpp_full_n", a_full_n, 1);
    tick();
    a_r = 1'b0;
    chk("a_fullpp_drain_occ", a_occ, 0);

    // A: pop-while-empty with simultaneous push (no bypass, data kept)
    a_w = 1'b1; a_r = 1'b1; a_din = 1'b1; a_exp.push_back(1'b1);
    tick();
    a_w = 1'b0;
    chk("a_emptypp_occ", a_occ, 1);
    chk("a_emptypp_empty_n", a_empty_n, 1);
    tick();
    a_r = 1'b0;
    chk("a_emptypp_drain_occ", a_occ, 0);
    chk("a_sb_drained", a_exp.size(), 0);

    // B: prefill 0,1 then stream 8 cycles of simultaneous push/pop
    b_wce = 1'b1; b_rce = 1'b1;
    b_w = 1'b1; b_din = 1'b0; b_exp.push_back(1'b0);
    tick();
    b_din = 1'b1; b_exp.push_back(1'b1);
    tick();
    chk("b_prefill_occ", b_occ, 2);
    b_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_din = stream[i];
      b_exp.push_back(stream[i]);
      tick();
      chk($sformatf("b_stream_occ_%0d", i), b_occ, 2);
    end
    b_w = 1'b0;
    chk("b_stream_hw", b_hw, 2);
    tick();
    tick();
    b_r = 1'b0;
    chk("b_drain_occ", b_occ, 0);
    chk("b_drain_empty_n", b_empty_n, 0);

    // B: fill to 3, drain to 1, clear high-water, then reset at occupancy 2
    b_w = 1'b1;
    b_din = 1'b1; b_exp.push_back(1'b1); tick();
    b_din = 1'b0; b_exp.push_back(1'b0); tick();
    b_din = 1'b1; b_exp.push_back(1'b1); tick();
    b_w = 1'b0;
    chk("b_fill3_occ", b_occ, 3);
    chk("b_fill3_hw", b_hw, 3);
    b_r = 1'b1;
    tick();
    tick();
    b_r = 1'b0;
    chk("b_drain1_occ", b_occ, 1);
    chk("b_drain1_hw", b_hw, 3);
    b_hwclr = 1'b1;
    tick();
    b_hwclr = 1'b0;
    chk("b_hwclr_hw", b_hw, 1);
    b_w = 1'b1; b_din = 1'b0; b_exp.push_back(1'b0);
    tick();
    chk("b_occ2_occ", b_occ, 2);
    chk("b_occ2_hw", b_hw, 2);
    b_din = 1'b1;
    rst_n = 1'b0;
    tick();
    b_exp.delete();
    rst_n = 1'b1;
    b_w = 1'b0;
    chk("b_mrst_occ", b_occ, 0);
    chk("b_mrst_empty_n", b_empty_n, 0);
    chk("b_mrst_full_n", b_full_n, 1);
    chk("b_mrst_hw", b_hw, 0);

    // B: normal operation after reset
    b_w = 1'b1; b_din = 1'b0; b_exp.push_back(1'b0);
    tick();
    b_din = 1'b1; b_exp.push_back(1'b1);
    tick();
    b_w = 1'b0;
    b_r = 1'b1;
    tick();
    tick();
    b_r = 1'b0;
    chk("b_post_occ", b_occ, 0);
    chk("b_sb_drained", b_exp.size(), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
